// File: rtl/mdu_unit.sv
// Iterative 32-bit multiply/divide unit owning HI/LO; MULT/DIV take 33 edges from start to HI/LO update.
// Latency 33 cycles for mult/div, 1 for MTHI/MTLO; start while busy is ignored, abort cancels in-flight work.
module mdu_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;
    localparam int CW = $clog2(ITER + 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;      // product high half / partial remainder
    logic [WIDTH-1:0] q;        // multiplier / dividend-quotient shift register
    logic [WIDTH-1:0] ma;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0] a_raw;
    logic             sa, sb, is_div, dz;
    logic [WIDTH-1:0] hi_r, lo_r;
    logic             done_r;

    logic             op_mul, op_div, op_sgn;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [2*WIDTH-1:0] prod_f;
    logic [WIDTH-1:0] quo_f, rem_f;

    always_comb begin
        op_mul  = (op == 3'b001) || (op == 3'b010);
        op_div  = (op == 3'b011) || (op == 3'b100);
        op_sgn  = (op == 3'b001) || (op == 3'b011);
        a_mag   = (op_sgn && A[WIDTH-1]) ? (~A + 1'b1) : A;
        b_mag   = (op_sgn && B[WIDTH-1]) ? (~B + 1'b1) : B;
        mul_sum = {1'b0, acc} + (q[0] ? {1'b0, ma} : '0);
        div_sh  = {acc, q[WIDTH-1]};
        div_ge  = div_sh >= {1'b0, ma};
        prod_f  = (sa ^ sb) ? (~{acc, q} + 1'b1) : {acc, q};
        quo_f   = (sa ^ sb) ? (~q + 1'b1) : q;
        rem_f   = sa ? (~acc + 1'b1) : acc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc    <= '0;
            q      <= '0;
            ma     <= '0;
            a_raw  <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            is_div <= 1'b0;
            dz     <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    // a flush in the same cycle also kills a newly issued op
                    if (start && !abort) begin
                        if (op_mul || op_div) begin
                            acc    <= '0;
                            ma     <= op_mul ? a_mag : b_mag;
                            q      <= op_mul ? b_mag : a_mag;
                            a_raw  <= A;
                            sa     <= op_sgn && A[WIDTH-1];
                            sb     <= op_sgn && B[WIDTH-1];
                            is_div <= op_div;
                            dz     <= op_div && (B == '0);
                            cnt    <= CW'(ITER);
                            state  <= op_mul ? S_MUL : S_DIV;
                        end else if (op == 3'b101) begin
                            hi_r <= A;
                        end else if (op == 3'b110) begin
                            lo_r <= A;
                        end
                    end
                end
                S_MUL: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= mul_sum[WIDTH:1];
                        q   <= {mul_sum[0], q[WIDTH-1:1]};
                        cnt <= cnt - 1'b1;
                        if (cnt == CW'(1)) state <= S_FIX;
                    end
                end
                S_DIV: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= div_ge ? (div_sh[WIDTH-1:0] - ma) : div_sh[WIDTH-1:0];
                        q   <= {q[WIDTH-2:0], div_ge};
                        cnt <= cnt - 1'b1;
                        if (cnt == CW'(1)) state <= S_FIX;
                    end
                end
                default: begin
                    if (!abort) begin
                        if (dz) begin
                            hi_r <= a_raw;
                            lo_r <= '1;
                        end else if (is_div) begin
                            hi_r <= rem_f;
                            lo_r <= quo_f;
                        end else begin
                            hi_r <= prod_f[2*WIDTH-1:WIDTH];
                            lo_r <= prod_f[WIDTH-1:0];
                        end
                        done_r <= 1'b1;
                    end
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;
endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit: mult/div results, latency, MTHI/MTLO, abort, async reset, back-to-back.
module tb_mdu_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [2:0]  op = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [2:0] OP_MULT = 3'b001, OP_MULTU = 3'b010, OP_DIV = 3'b011,
                           OP_DIVU = 3'b100, OP_MTHI = 3'b101, OP_MTLO = 3'b110;

    mdu_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .op(op), .start(start),
        .abort(abort), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one start cycle from the current time; returns #1 after the sampling edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; op = 3'b000;
    endtask

    task automatic wait_done(input int n_exp, input logic [31:0] eh, input logic [31:0] el,
                             input string tag);
        logic [31:0] oh, ol;
        int n;
        logic changed, idle_early;
        oh = hi; ol = lo; n = 0; changed = 1'b0; idle_early = 1'b0;
        while (n < 60) begin
            @(posedge clk); #1;
            n++;
            if (done) break;
            if (hi !== oh || lo !== ol) changed = 1'b1;
            if (!busy) idle_early = 1'b1;
        end
        chk({tag, "_latency"}, 64'(n), 64'(n_exp));
        chk({tag, "_hold"}, {63'd0, changed | idle_early}, 64'd0);
        chk({tag, "_hi"}, {32'd0, hi}, {32'd0, eh});
        chk({tag, "_lo"}, {32'd0, lo}, {32'd0, el});
        chk({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        #2;
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);

        issue(OP_MULT, 32'hFFFFFFFD, 32'd5);
        chk("mult_busy_t0", {63'd0, busy}, 64'd1);
        wait_done(33, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult_neg");
        @(posedge clk); #1;
        chk("mult_done_once", {63'd0, done}, 64'd0);

        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(33, 32'hFFFFFFFE, 32'h00000001, "multu_max");

        @(posedge clk); #1;
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
        wait_done(33, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
        @(posedge clk); #1;
        issue(OP_DIVU, 32'hFFFFFFF9, 32'd2);
        wait_done(33, 32'h00000001, 32'h7FFFFFFC, "divu");

        @(posedge clk); #1;
        issue(OP_DIVU, 32'd7, 32'd0);
        wait_done(33, 32'd7, 32'hFFFFFFFF, "divu_by0");
        @(posedge clk); #1;
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done(33, 32'd0, 32'h80000000, "div_ovf");

        @(posedge clk); #1;
        issue(OP_MTHI, 32'h12345678, 32'd0);
        chk("mthi_hi", {32'd0, hi}, {32'd0, 32'h12345678});
        chk("mthi_lo", {32'd0, lo}, {32'd0, 32'h80000000});
        chk("mthi_busy", {63'd0, busy}, 64'd0);
        chk("mthi_done", {63'd0, done}, 64'd0);

        // MTLO while busy must be dropped
        issue(OP_MULT, 32'd6, 32'd7);
        issue(OP_MTLO, 32'hDEADBEEF, 32'd0);
        wait_done(32, 32'd0, 32'd42, "mult_mtlo_busy");

        // abort at cycle 10 of a DIV, with a MULT start in the same cycle
        @(posedge clk); #1;
        issue(OP_DIV, 32'd100, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        abort = 1'b1;
        issue(OP_MULT, 32'd2, 32'd3);
        abort = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (busy || done) seen = 1'b1;
        end
        chk("abort_quiet", {63'd0, seen}, 64'd0);
        chk("abort_hi", {32'd0, hi}, 64'd0);
        chk("abort_lo", {32'd0, lo}, 64'd42);

        issue(OP_MULT, 32'h00010000, 32'h00010000);
        wait_done(33, 32'd1, 32'd0, "mult_after_abort");

        // asynchronous reset mid-MULT
        @(posedge clk); #1;
        issue(OP_MULT, 32'd3, 32'd4);
        repeat (19) @(posedge clk);
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        chk("arst_hi", {32'd0, hi}, 64'd0);
        chk("arst_lo", {32'd0, lo}, 64'd0);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_done", {63'd0, done}, 64'd0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);

        // back-to-back: new start in the done cycle
        issue(OP_MULT, 32'd5, 32'd5);
        wait_done(33, 32'd0, 32'd25, "b2b_first");
        issue(OP_MULTU, 32'hFFFFFFFF, 32'd2);
        chk("b2b_busy", {63'd0, busy}, 64'd1);
        wait_done(33, 32'd1, 32'hFFFFFFFE, "b2b_second");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
